// File: rtl/seg_led_disp_lbus.sv
// LBUS output peripheral: an LED register and a 4-digit multiplexed hex display.
// The display has per-digit enable, decimal points and 16-level PWM brightness.
package lb_pkg;
   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic        MatchWLB;
      logic        MatchRLB;
   } lb_slave_t;
endpackage

module seg_led_disp_lbus #(
   parameter int CLK_DIV = 1000
) (
   input  logic             lb_clk,
   input  logic             rst_n,
   input  lb_pkg::lb_slave_t xt_lb,
   output logic [15:0]      rdata,
   output logic [7:0]       led,
   output logic [7:0]       seg,
   output logic [3:0]       dig_sel
);

   localparam int PW = $clog2(CLK_DIV);

   logic [7:0]    led_reg;
   logic [15:0]   seg_data;
   logic [11:0]   ctrl_reg;
   logic [PW-1:0] presc;
   logic [3:0]    slot;
   logic [1:0]    idx;
   logic          tick;
   logic          active;
   logic [3:0]    nibble;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         led_reg  <= '0;
         seg_data <= '0;
         ctrl_reg <= '0;
      end else if (xt_lb.MatchWLB) begin
         case (xt_lb.addr)
            8'h00: led_reg  <= xt_lb.wdata[7:0];
            8'h02: seg_data <= xt_lb.wdata;
            8'h04: ctrl_reg <= xt_lb.wdata[11:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (xt_lb.MatchRLB) begin
         case (xt_lb.addr)
            8'h00: rdata = {8'h00, led_reg};
            8'h02: rdata = seg_data;
            8'h04: rdata = {4'h0, ctrl_reg};
            8'h06: rdata = {10'h000, slot, idx};
            default: rdata = '0;
         endcase
      end
   end

   assign tick = (presc == PW'(CLK_DIV - 1));

   // Scan runs freely regardless of register writes; a disabled digit still uses its slot time.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         slot  <= '0;
         idx   <= '0;
      end else if (tick) begin
         presc <= '0;
         slot  <= slot + 4'd1;
         if (slot == 4'd15)
            idx <= idx + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Slot 15 never satisfies slot < B, leaving dead time before every digit change.
   always_comb begin
      nibble = seg_data[idx*4 +: 4];
      active = ctrl_reg[idx] && (slot < ctrl_reg[11:8]);
   end

   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         led     <= 8'h00;
         seg     <= 8'hFF;
         dig_sel <= 4'hF;
      end else begin
         led <= led_reg;
         if (active) begin
            dig_sel <= ~(4'b0001 << idx);
            seg     <= {~ctrl_reg[4 + idx], hex7(nibble)};
         end else begin
            dig_sel <= 4'hF;
            seg     <= 8'hFF;
         end
      end
   end

endmodule
